load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_align.sv | 47 ++++
 rtl/load_store_unit.sv | 118 +++++++++++
 tb/tb_load_store_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 codes, access
// size decode and the latched per-access descriptor.
package lsu_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic      is_store;
    lsu_size_e size;
    logic      is_unsigned;
    logic [1:0] offset;
  } lsu_op_t;

  // Unused funct3 encodings fall through to a full-word access.
  function automatic lsu_size_e decode_size(input logic [2:0] f3);
    lsu_size_e sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/half lane handling: extracts and extends a load from a memory word,
// and merges store data into a memory word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  lsu_size_e        size,
  input  logic             is_unsigned,
  input  logic [1:0]       offset,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] load_data_c,
  output logic [WIDTH-1:0] merge_data_c
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  always_comb begin
    byte_lane = word[{offset, 3'b000} +: BYTE_W];
    half_lane = word[{offset[1], 4'b0000} +: HALF_W];
  end

  // Load path: pick the lane, then sign- or zero-extend.
  always_comb begin
    load_data_c = word;
    case (size)
      SZ_B: load_data_c = is_unsigned ? WIDTH'(byte_lane)
                                      : {{(WIDTH-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
      SZ_H: load_data_c = is_unsigned ? WIDTH'(half_lane)
                                      : {{(WIDTH-HALF_W){half_lane[HALF_W-1]}}, half_lane};
      default: load_data_c = word;
    endcase
  end

  // Store path: overwrite only the addressed lanes of the old word.
  always_comb begin
    merge_data_c = word;
    case (size)
      SZ_B:    merge_data_c[{offset, 3'b000} +: BYTE_W]    = store_data[BYTE_W-1:0];
      SZ_H:    merge_data_c[{offset[1], 4'b0000} +: HALF_W] = store_data[HALF_W-1:0];
      default: merge_data_c = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences word-wide memory requests for byte/half/word
// loads and stores, doing read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  output logic [WIDTH-1:0] ReadData,
  output logic             Stall,
  output logic             Misaligned,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  lsu_state_e       state_q, state_d;
  lsu_op_t          op_q;
  lsu_size_e        size_c;
  logic             req_c, misal_c, start_c;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [WIDTH-1:0] load_data_c, merge_data_c;

  // Request decode; a simultaneous read+write is a store.
  always_comb begin
    req_c   = MemRead | MemWrite;
    size_c  = decode_size(funct3);
    misal_c = req_c & is_misaligned(size_c, ALUResult[1:0]);
    start_c = req_c & ~misal_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_c) state_d = (MemWrite && size_c == SZ_W) ? WR : RD;
      RD:   if (mem_ack) state_d = op_q.is_store ? WR : DONE;
      WR:   if (mem_ack) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall and Misaligned answer the CPU in the request cycle itself.
  always_comb begin
    Stall      = 1'b0;
    Misaligned = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        Stall      = start_c & rst_n;
        Misaligned = misal_c & rst_n;
      end
      RD: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
      end
      WR: begin
        Stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Access descriptor, address and data latched at request acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && start_c) begin
        op_q    <= '{is_store: MemWrite, size: size_c,
                     is_unsigned: funct3[2], offset: ALUResult[1:0]};
        addr_q  <= {ALUResult[WIDTH-1:2], 2'b00};
        wdata_q <= WriteData;
      end
      if (state_q == RD && mem_ack) begin
        if (op_q.is_store) wdata_q <= merge_data_c;
        else               rdata_q <= load_data_c;
      end
    end
  end

  lsu_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .size        (op_q.size),
    .is_unsigned (op_q.is_unsigned),
    .offset      (op_q.offset),
    .word        (mem_rdata),
    .store_data  (wdata_q),
    .load_data_c (load_data_c),
    .merge_data_c(merge_data_c)
  );

  assign ReadData  = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random
// loads/stores against a word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        Stall, Misaligned, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [int];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Misaligned(Misaligned),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] rd_word(input int idx);
    if (!mem.exists(idx)) mem[idx] = $urandom;
    return mem[idx];
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    int nb = size_bytes(f3);
    logic [31:0] mask, v;
    if (nb == 4) return w;
    mask = (nb == 1) ? 32'hFF : 32'hFFFF;
    v = (w >> (8 * off)) & mask;
    if (!f3[2] && v > (mask >> 1)) v = v - (mask + 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input int nb, input logic [1:0] off);
    logic [31:0] mask;
    if (nb == 4) return wd;
    mask = (nb == 1) ? 32'hFF : 32'hFFFF;
    return (old & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
  endfunction

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    funct3    = 3'b000;
    ALUResult = 32'h0;
    WriteData = 32'h0;
  endtask

  // One memory transfer: request must stay up until the ack in cycle dly.
  task automatic mem_phase(input logic we, input int dly, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           inout int stall_cyc, output logic [31:0] seen_addr,
                           output logic [31:0] seen_data);
    seen_addr = '0;
    seen_data = '0;
    for (int c = 0; c <= dly; c++) begin
      @(negedge clk);
      mem_ack   = (c == dly);
      mem_rdata = rdata;
      #1;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(we));
      if (Stall) stall_cyc++;
      if (c == dly) begin
        chk("mem_addr", mem_addr, exp_addr);
        if (we) chk("mem_wdata", mem_wdata, exp_wdata);
        seen_addr = mem_addr;
        seen_data = mem_wdata;
      end
    end
  endtask

  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int dly,
                       output logic [31:0] got_rd, output int stall_cyc,
                       output logic [31:0] got_wa, output logic [31:0] got_wd);
    int nb = size_bytes(f3);
    int idx = int'(addr >> 2);
    logic misal = (addr & 32'(nb - 1)) != 32'd0;
    logic [31:0] exp_addr = addr & ~32'h3;
    logic [31:0] old, exp_w, sa, sd;
    got_rd = '0;
    got_wa = '0;
    got_wd = '0;
    stall_cyc = 0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUResult = addr; WriteData = wd;
    mem_ack = 1'b0;
    #1;
    if (misal) begin
      chk("misal_pulse", 32'(Misaligned), 32'd1);
      chk("misal_stall", 32'(Stall), 32'd0);
      chk("misal_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("misal_once", 32'(Misaligned), 32'd0);
      chk("misal_noreq", 32'(mem_req), 32'd0);
      return;
    end
    chk("req_stall", 32'(Stall), 32'd1);
    chk("req_nomisal", 32'(Misaligned), 32'd0);
    chk("req_idle", 32'(mem_req), 32'd0);
    old = rd_word(idx);
    if (!wr || nb != 4) mem_phase(1'b0, dly, old, exp_addr, 32'h0, stall_cyc, sa, sd);
    if (wr) begin
      exp_w = merge(old, wd, nb, addr[1:0]);
      mem_phase(1'b1, dly, $urandom, exp_addr, exp_w, stall_cyc, got_wa, got_wd);
      mem[idx] = exp_w;
    end else begin
      last_rd = load_ext(old, f3, addr[1:0]);
    end
    // DONE: a stray ack here must be ignored.
    @(negedge clk);
    mem_ack = 1'($urandom);
    #1;
    chk("done_stall", 32'(Stall), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_rdata", ReadData, last_rd);
    got_rd = ReadData;
    @(negedge clk);
    idle_inputs();
    mem_ack = 1'b0;
    #1;
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_stall", 32'(Stall), 32'd0);
    chk("hold_rdata", ReadData, last_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [31:0] g_rd, g_wa, g_wd;
    int g_st;
    rst_n = 1'b0;
    last_rd = '0;
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h10; WriteData = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    ALUResult = 32'h6;
    #1;
    chk("rst_misal", 32'(Misaligned), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    mem[4] = 32'hDEADBEEF;
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1, g_rd, g_st, g_wa, g_wd);
    chk("lw_data", g_rd, 32'hDEADBEEF);
    chk("lw_stall_cycles", 32'(g_st), 32'd2);

    mem[4] = 32'h80FF7F01;
    do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 0, g_rd, g_st, g_wa, g_wd);
    chk("lb_sext", g_rd, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 2, g_rd, g_st, g_wa, g_wd);
    chk("lbu_zext", g_rd, 32'h00000080);
    do_op(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 0, g_rd, g_st, g_wa, g_wd);
    chk("lh_sext", g_rd, 32'hFFFF80FF);

    mem[8] = 32'h11223344;
    do_op(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AB, 1, g_rd, g_st, g_wa, g_wd);
    chk("sb_merge", g_wd, 32'h1122AB44);
    chk("sb_addr", g_wa, 32'h20);

    do_op(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 0, g_rd, g_st, g_wa, g_wd);

    do_op(1'b0, 1'b1, 3'b010, 32'h0C, 32'h12345678, 0, g_rd, g_st, g_wa, g_wd);
    chk("sw_stall_cycles", 32'(g_st), 32'd1);
    chk("sw_wdata", g_wd, 32'h12345678);

    do_op(1'b1, 1'b1, 3'b001, 32'h32, 32'h0000BEEF, 1, g_rd, g_st, g_wa, g_wd);
    do_op(1'b1, 1'b0, 3'b111, 32'h0C, 32'h0, 0, g_rd, g_st, g_wa, g_wd);
    chk("unused_f3_word", g_rd, 32'h12345678);

    // Reset while a write is outstanding.
    @(negedge clk);
    MemWrite = 1'b1; funct3 = 3'b010; ALUResult = 32'h40; WriteData = 32'hCAFEF00D;
    mem_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("wr_pending_req", 32'(mem_req), 32'd1);
    chk("wr_pending_we", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_stall", 32'(Stall), 32'd0);
    chk("abort_rdata", ReadData, 32'd0);
    idle_inputs();
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, g_rd, g_st, g_wa, g_wd);

    for (int i = 0; i < 200; i++) begin
      int k = $urandom_range(0, 2);
      logic r = (k != 1);
      logic w = (k != 0);
      logic [2:0] f3 = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      do_op(r, w, f3, 32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 3),
            g_rd, g_st, g_wa, g_wd);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
